// File: rtl/mux_nch_reg.sv
// -----------------------------------------------------------------------------
// mux_nch_reg
//
// N-channel, W-bit registered multiplexer with a valid/ready output port.
// It has three operating modes:
//   00 manual : the channel index comes from sel_i.
//   01 scan   : the index steps round-robin 0..N-1.
//               Each index is presented for DWELL accepted cycles.
//   10 hold   : output and scan position are frozen (11 behaves the same).
//
// Ports
//   clk          single clock, rising edge
//   rst          asynchronous, active-high reset
//   in_data_i    N*W packed channels, channel c at [c*W +: W]
//   sel_i        channel index used in manual mode
//   mode_i       operating mode (see above)
//   out_ready_i  sink accepts out_data_o this cycle
//   out_data_o   registered data of the selected channel
//   out_ch_o     logical index (not the physical channel) behind out_data_o
//   out_valid_o  out_data_o / out_ch_o are valid (set once out of reset)
//   scan_wrap_o  one-cycle pulse on the edge where the scan index returns to 0
//   sel_err_o    one-cycle pulse when an accepted manual sel_i is >= N
//
// Index k maps to physical channel N-1-k when REVERSE=1, else to channel k.
// -----------------------------------------------------------------------------
module mux_nch_reg #(
    parameter int N       = 4,
    parameter int W       = 1,
    parameter int DWELL   = 1,
    parameter int REVERSE = 1,
    localparam int SW     = $clog2(N)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N*W-1:0]    in_data_i,
    input  logic [SW-1:0]     sel_i,
    input  logic [1:0]        mode_i,
    input  logic              out_ready_i,
    output logic [W-1:0]      out_data_o,
    output logic [SW-1:0]     out_ch_o,
    output logic              out_valid_o,
    output logic              scan_wrap_o,
    output logic              sel_err_o
);

    typedef enum logic [1:0] {
        MODE_MANUAL = 2'b00,
        MODE_SCAN   = 2'b01,
        MODE_HOLD   = 2'b10,
        MODE_RSVD   = 2'b11
    } mode_e;

    // The channel table is padded to a power of two.
    // Any SW-bit index therefore lands on a defined entry.
    localparam int NP2 = 1 << SW;
    // The dwell counter is at least one bit wide, even for DWELL=1.
    localparam int DW  = (DWELL > 1) ? $clog2(DWELL) : 1;

    localparam logic [SW-1:0] LAST_IDX   = SW'(N - 1);
    localparam logic [DW-1:0] LAST_DWELL = DW'(DWELL - 1);

    // -------------------------------------------------------------------------
    // Channel unpacking
    // -------------------------------------------------------------------------
    logic [W-1:0] chan [NP2];

    generate
        for (genvar gi = 0; gi < NP2; gi++) begin : g_chan
            if (gi < N) begin : g_real
                assign chan[gi] = in_data_i[gi*W +: W];
            end else begin : g_pad
                assign chan[gi] = '0;
            end
        end
    endgenerate

    // sel_i can only exceed the channel count when N is not a power of two.
    logic sel_in_range;

    generate
        if (NP2 == N) begin : g_sel_full
            assign sel_in_range = 1'b1;
        end else begin : g_sel_part
            assign sel_in_range = (sel_i < SW'(N));
        end
    endgenerate

    function automatic logic [SW-1:0] phys_of(input logic [SW-1:0] k);
        if (REVERSE != 0) begin
            return LAST_IDX - k;
        end
        return k;
    endfunction

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    // The presented index always equals out_ch_o.
    // A single register therefore serves as both idx and out_ch.
    logic [SW-1:0] idx_q,        idx_d;
    logic [DW-1:0] dwell_q,      dwell_d;
    logic [W-1:0]  data_q,       data_d;
    logic          valid_q;
    logic          wrap_q,       wrap_d;
    logic          err_q,        err_d;
    mode_e         prev_mode_q;
    logic          pend_q,       pend_d;

    mode_e cur_mode;
    logic  adv;
    logic  scan_entry;
    logic  load;

    assign cur_mode = mode_e'(mode_i);
    assign adv      = !valid_q || out_ready_i;

    // A scan restart is owed in two cases:
    //   - the mode just switched to scan, or
    //   - an earlier entry into scan fell on a stalled cycle (pend_q).
    // prev_mode_q keeps updating during a stall.
    // pend_q is what carries the owed restart across that stall.
    assign scan_entry = (cur_mode == MODE_SCAN) &&
                        ((prev_mode_q != MODE_SCAN) || pend_q);

    always_comb begin
        idx_d   = idx_q;
        dwell_d = dwell_q;
        wrap_d  = 1'b0;
        err_d   = 1'b0;
        pend_d  = pend_q;
        load    = 1'b0;

        case (cur_mode)
            MODE_MANUAL: begin
                pend_d = 1'b0;
                if (adv) begin
                    dwell_d = '0;
                    if (sel_in_range) begin
                        idx_d = sel_i;
                        load  = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end

            MODE_SCAN: begin
                if (adv) begin
                    load   = 1'b1;
                    pend_d = 1'b0;
                    if (scan_entry) begin
                        idx_d   = '0;
                        dwell_d = '0;
                    end else if (dwell_q == LAST_DWELL) begin
                        dwell_d = '0;
                        if (idx_q == LAST_IDX) begin
                            idx_d  = '0;
                            wrap_d = 1'b1;
                        end else begin
                            idx_d = idx_q + 1'b1;
                        end
                    end else begin
                        dwell_d = dwell_q + 1'b1;
                    end
                end else if (scan_entry) begin
                    pend_d = 1'b1;
                end
            end

            default: begin
                // Hold and reserved: everything frozen.
                pend_d = 1'b0;
            end
        endcase

        // The output carries the index presented after this edge.
        // Channel data is re-sampled on every accepted cycle.
        // This lets live input changes show through during a dwell.
        data_d = load ? chan[phys_of(idx_d)] : data_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_q       <= '0;
            dwell_q     <= '0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            wrap_q      <= 1'b0;
            err_q       <= 1'b0;
            prev_mode_q <= MODE_HOLD;
            pend_q      <= 1'b0;
        end else begin
            idx_q       <= idx_d;
            dwell_q     <= dwell_d;
            data_q      <= data_d;
            valid_q     <= 1'b1;
            wrap_q      <= wrap_d;
            err_q       <= err_d;
            prev_mode_q <= cur_mode;
            pend_q      <= pend_d;
        end
    end

    assign out_data_o  = data_q;
    assign out_ch_o    = idx_q;
    assign out_valid_o = valid_q;
    assign scan_wrap_o = wrap_q;
    assign sel_err_o   = err_q;

endmodule

// File: tb/tb_mux_nch_reg.sv
module tb_mux_nch_reg;

    logic clk = 1'b0;
    logic rst = 1'b0;

    always #5 clk = ~clk;

    logic [1:0]  mode;
    logic [2:0]  sel5;
    logic [1:0]  sel4;
    logic        ready;
    logic [31:0] in4;
    logic [39:0] in5;

    assign sel4 = sel5[1:0];

    logic [7:0] a_data, b_data, c_data, e_data;
    logic [1:0] a_ch, b_ch, c_ch;
    logic [2:0] e_ch;
    logic       a_v, a_w, a_e;
    logic       b_v, b_w, b_e;
    logic       c_v, c_w, c_e;
    logic       e_v, e_w, e_e;

    // Instance 0: N=4, REVERSE=1, DWELL=1
    mux_nch_reg #(.N(4), .W(8), .DWELL(1), .REVERSE(1)) u_a (
        .clk(clk), .rst(rst), .in_data_i(in4), .sel_i(sel4), .mode_i(mode),
        .out_ready_i(ready), .out_data_o(a_data), .out_ch_o(a_ch),
        .out_valid_o(a_v), .scan_wrap_o(a_w), .sel_err_o(a_e));

    // Instance 1: N=4, REVERSE=0, DWELL=3
    mux_nch_reg #(.N(4), .W(8), .DWELL(3), .REVERSE(0)) u_b (
        .clk(clk), .rst(rst), .in_data_i(in4), .sel_i(sel4), .mode_i(mode),
        .out_ready_i(ready), .out_data_o(b_data), .out_ch_o(b_ch),
        .out_valid_o(b_v), .scan_wrap_o(b_w), .sel_err_o(b_e));

    // Instance 2: N=4, REVERSE=0, DWELL=1
    mux_nch_reg #(.N(4), .W(8), .DWELL(1), .REVERSE(0)) u_c (
        .clk(clk), .rst(rst), .in_data_i(in4), .sel_i(sel4), .mode_i(mode),
        .out_ready_i(ready), .out_data_o(c_data), .out_ch_o(c_ch),
        .out_valid_o(c_v), .scan_wrap_o(c_w), .sel_err_o(c_e));

    // Instance 3: N=5, REVERSE=0, DWELL=1
    mux_nch_reg #(.N(5), .W(8), .DWELL(1), .REVERSE(0)) u_e (
        .clk(clk), .rst(rst), .in_data_i(in5), .sel_i(sel5), .mode_i(mode),
        .out_ready_i(ready), .out_data_o(e_data), .out_ch_o(e_ch),
        .out_valid_o(e_v), .scan_wrap_o(e_w), .sel_err_o(e_e));

    typedef struct {
        string      tag;
        int         dut;
        logic [7:0] data;
        logic [2:0] ch;
        logic       valid;
        logic       wrap;
        logic       err;
    } exp_t;

    exp_t sb[$];
    int   vectors     = 0;
    int   miscompares = 0;

    task automatic chk(input string tag, input string field, input int d,
                       input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s.%s dut%0d observed=%0h expected=%0h",
                   tag, field, d, obs, exp);
        end
    endtask

    task automatic get_obs(input int d, output logic [7:0] dat,
                           output logic [2:0] ch, output logic v,
                           output logic w, output logic e);
        case (d)
            0: begin dat = a_data; ch = {1'b0, a_ch}; v = a_v; w = a_w; e = a_e; end
            1: begin dat = b_data; ch = {1'b0, b_ch}; v = b_v; w = b_w; e = b_e; end
            2: begin dat = c_data; ch = {1'b0, c_ch}; v = c_v; w = c_w; e = c_e; end
            default: begin dat = e_data; ch = e_ch; v = e_v; w = e_w; e = e_e; end
        endcase
    endtask

    task automatic expect_out(input string tag, input int d,
                              input logic [7:0] data, input logic [2:0] ch,
                              input logic valid, input logic wrap,
                              input logic err);
        exp_t x;
        x.tag = tag; x.dut = d; x.data = data; x.ch = ch;
        x.valid = valid; x.wrap = wrap; x.err = err;
        sb.push_back(x);
    endtask

    task automatic compare_front();
        exp_t       x;
        logic [7:0] dat;
        logic [2:0] ch;
        logic       v, w, e;
        x = sb.pop_front();
        get_obs(x.dut, dat, ch, v, w, e);
        chk(x.tag, "data",  x.dut, 32'(dat), 32'(x.data));
        chk(x.tag, "ch",    x.dut, 32'(ch),  32'(x.ch));
        chk(x.tag, "valid", x.dut, 32'(v),   32'(x.valid));
        chk(x.tag, "wrap",  x.dut, 32'(w),   32'(x.wrap));
        chk(x.tag, "err",   x.dut, 32'(e),   32'(x.err));
        $display("txn %-8s dut%0d data=%02h ch=%0d valid=%0b wrap=%0b err=%0b",
                 x.tag, x.dut, dat, ch, v, w, e);
    endtask

    // Apply the current inputs for one edge.
    // The expected outputs are queued first and checked 1ns after the edge.
    task automatic step(input string tag, input int d, input logic [7:0] data,
                        input logic [2:0] ch, input logic wrap,
                        input logic err);
        expect_out(tag, d, data, ch, 1'b1, wrap, err);
        @(posedge clk);
        #1;
        compare_front();
    endtask

    task automatic check_reset(input string tag);
        for (int d = 0; d < 4; d++) begin
            expect_out(tag, d, 8'h00, 3'd0, 1'b0, 1'b0, 1'b0);
            compare_front();
        end
    endtask

    // Asynchronous reset pulse, raised and released between clock edges.
    task automatic pulse_reset(input string tag);
        rst = 1'b1;
        #2;
        check_reset(tag);
        rst = 1'b0;
    endtask

    localparam logic [31:0] BASE4 = 32'h13121110;
    localparam logic [39:0] BASE5 = 40'h1413121110;

    initial begin
        int scan_seq [13] = '{0, 0, 0, 1, 1, 1, 2, 2, 2, 3, 3, 3, 0};

        mode  = 2'b00;
        sel5  = 3'd0;
        ready = 1'b1;
        in4   = BASE4;
        in5   = BASE5;

        // Power-on reset
        #1 rst = 1'b1;
        #1;
        check_reset("rst0");
        #10 rst = 1'b0;

        // Manual mode, reversed mapping, one-cycle latency
        step("man_rev", 0, 8'h13, 3'd0, 1'b0, 1'b0);
        sel5 = 3'd2;
        step("man_rev", 0, 8'h11, 3'd2, 1'b0, 1'b0);

        // Manual mode, direct mapping
        sel5 = 3'd1;
        step("man_fwd", 2, 8'h11, 3'd1, 1'b0, 1'b0);

        // N=5 out-of-range select
        sel5 = 3'd6;
        step("sel_err", 3, 8'h11, 3'd1, 1'b0, 1'b1);
        sel5 = 3'd1;
        step("sel_ok", 3, 8'h11, 3'd1, 1'b0, 1'b0);

        // Scan with DWELL=3, entered from manual
        mode = 2'b01;
        for (int i = 0; i < 13; i++) begin
            step("scan3", 1, 8'(8'h10 + scan_seq[i]), 3'(scan_seq[i]),
                 (i == 12), 1'b0);
        end

        // Back-pressure, DWELL=1
        mode = 2'b00;
        pulse_reset("rst_bp");
        mode = 2'b01;
        step("bp", 2, 8'h10, 3'd0, 1'b0, 1'b0);
        step("bp", 2, 8'h11, 3'd1, 1'b0, 1'b0);
        step("bp", 2, 8'h12, 3'd2, 1'b0, 1'b0);
        ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step("stall", 2, 8'h12, 3'd2, 1'b0, 1'b0);
        end
        ready = 1'b1;
        step("bp", 2, 8'h13, 3'd3, 1'b0, 1'b0);
        step("bp_wrap", 2, 8'h10, 3'd0, 1'b1, 1'b0);
        step("bp", 2, 8'h11, 3'd1, 1'b0, 1'b0);

        // Hold freezes the output while inputs move
        mode = 2'b10;
        for (int i = 0; i < 5; i++) begin
            in4   = $urandom;
            ready = 1'(i & 1);
            step("hold", 2, 8'h11, 3'd1, 1'b0, 1'b0);
        end
        in4   = BASE4;
        ready = 1'b1;
        mode  = 2'b01;
        step("hold_ex", 2, 8'h10, 3'd0, 1'b0, 1'b0);
        step("scan", 2, 8'h11, 3'd1, 1'b0, 1'b0);
        step("scan", 2, 8'h12, 3'd2, 1'b0, 1'b0);

        // Async reset mid-scan, then restart from index 0
        pulse_reset("rst_mid");
        step("rst_scan", 2, 8'h10, 3'd0, 1'b0, 1'b0);
        step("rst_scan", 2, 8'h11, 3'd1, 1'b0, 1'b0);

        // Entry into scan during a stall is applied at the first accept
        mode = 2'b00;
        sel5 = 3'd3;
        step("man3", 2, 8'h13, 3'd3, 1'b0, 1'b0);
        ready = 1'b0;
        mode  = 2'b01;
        step("ent_stl", 2, 8'h13, 3'd3, 1'b0, 1'b0);
        step("ent_stl", 2, 8'h13, 3'd3, 1'b0, 1'b0);
        ready = 1'b1;
        step("ent_go", 2, 8'h10, 3'd0, 1'b0, 1'b0);
        step("ent_go", 2, 8'h11, 3'd1, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
